// File: rtl/des_sbox_seq_pkg.sv
// Shared DES S-box constants, lookup table and sequencer state type.
package des_pkg;

  localparam int unsigned DES_CHUNK_W = 6;
  localparam int unsigned DES_NIB_W   = 4;
  localparam int unsigned DES_NBOX    = 8;
  localparam int unsigned DES_EXP_W   = 48;
  localparam int unsigned DES_HALF_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } des_state_e;

  // Indexed [box][row*16+col]; each box literal lists rows 0..3, columns 0..15, leftmost first.
  localparam logic [0:DES_NBOX-1][0:63][DES_NIB_W-1:0] DES_SBOX = {
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

endpackage

// File: rtl/des_sbox_lane.sv
// One combinational DES S-box lookup with a selectable box.
module des_sbox_lane
  import des_pkg::*;
(
  input  logic [2:0]             box,
  input  logic [DES_CHUNK_W-1:0] chunk,
  output logic [DES_NIB_W-1:0]   nib
);

  logic [5:0] idx;

  always_comb begin
    // row = outer bits, column = inner four bits
    idx = {chunk[5], chunk[0], chunk[4:1]};
    nib = DES_SBOX[box][idx];
  end

endmodule

// File: rtl/des_sbox_seq.sv
// Handshaked DES S-box substitution, LANES lookups per cycle over 8/LANES beats.
module des_sbox_seq
  import des_pkg::*;
#(
  parameter  int unsigned LANES = 2,
  localparam int unsigned BEATS = 8 / LANES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DES_EXP_W-1:0]  in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DES_HALF_W-1:0] out_data,
  output logic                  busy
);

  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8) begin : g_bad_lanes
    $error("des_sbox_seq: LANES must be 1, 2, 4 or 8");
  end

  des_state_e                 state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [DES_EXP_W-1:0]       sreg_q, sreg_d;
  logic [DES_HALF_W-1:0]      acc_q, acc_d;
  logic [DES_NIB_W*LANES-1:0] lane_nib;

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [2:0] box_sel;
    assign box_sel = 3'(cnt_q * LANES) + 3'(j);

    des_sbox_lane u_lane (
      .box   (box_sel),
      .chunk (sreg_q[DES_EXP_W-1-DES_CHUNK_W*j -: DES_CHUNK_W]),
      .nib   (lane_nib[DES_NIB_W*(LANES-j)-1 -: DES_NIB_W])
    );
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sreg_d   = sreg_q;
    acc_d    = acc_q;
    in_ready = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sreg_d  = in_data;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sreg_d = sreg_q << (DES_CHUNK_W * LANES);
        acc_d  = (acc_q << (DES_NIB_W * LANES)) | DES_HALF_W'(lane_nib);
        // counter parks on the last beat instead of wrapping
        if (cnt_q == CNT_W'(BEATS - 1)) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            sreg_d  = in_data;
            cnt_d   = '0;
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      acc_q   <= acc_d;
    end
  end

  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN);
  assign out_data  = acc_q;

endmodule

// File: tb/tb_des_sbox_seq.sv
// Scoreboard bench driving four des_sbox_seq instances (LANES = 1, 2, 4, 8).
module tb_des_sbox_seq;

  localparam int NI = 4;
  localparam logic [31:0] R_ZERO = 32'hEFA72C4D;
  localparam logic [31:0] R_ONES = 32'hD9CE3DCB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NI-1:0] rst_n_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, busy_a;
  logic [47:0]   in_data_a  [NI];
  logic [31:0]   out_data_a [NI];

  logic [31:0] exp_q [NI][$];
  int xfer_cnt [NI] = '{0, 0, 0, 0};
  int n_vec = 0;
  int n_err = 0;

  // Reference DES boxes, [box][row][col]
  int SB [8][4][16] = '{
    '{'{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7}, '{0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8},
      '{4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0}, '{15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13}},
    '{'{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10}, '{3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5},
      '{0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15}, '{13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9}},
    '{'{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8}, '{13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1},
      '{13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7}, '{1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12}},
    '{'{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15}, '{13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9},
      '{10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4}, '{3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14}},
    '{'{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9}, '{14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6},
      '{4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14}, '{11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3}},
    '{'{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11}, '{10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8},
      '{9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6}, '{4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13}},
    '{'{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1}, '{13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6},
      '{1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2}, '{6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12}},
    '{'{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7}, '{1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2},
      '{7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8}, '{2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}}
  };

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    des_sbox_seq #(.LANES(1 << gi)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n_a[gi]),
      .in_valid  (in_valid_a[gi]),
      .in_ready  (in_ready_a[gi]),
      .in_data   (in_data_a[gi]),
      .out_valid (out_valid_a[gi]),
      .out_ready (out_ready_a[gi]),
      .out_data  (out_data_a[gi]),
      .busy      (busy_a[gi])
    );
  end

  function automatic int beats_of(input int i);
    return 8 >> i;
  endfunction

  function automatic logic [3:0] ref_nib(input int b, input logic [5:0] c);
    return 4'(SB[b][{c[5], c[0]}][c[4:1]]);
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s lanes=%0d: got %h, required %h", nm, 1 << i, act, exp);
    end
  endtask

  task automatic fail_timeout(input string nm, input int i);
    n_vec++;
    n_err++;
    $display("FAIL %s lanes=%0d: got no event within bound, required one", nm, 1 << i);
  endtask

  // Scoreboard monitor: a transfer is out_valid && out_ready seen mid-cycle
  always @(negedge clk) begin
    for (int m = 0; m < NI; m++) begin
      if (rst_n_a[m] && out_valid_a[m] && out_ready_a[m]) begin
        xfer_cnt[m]++;
        if (exp_q[m].size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_out lanes=%0d: got %h, required no result", 1 << m, out_data_a[m]);
        end else begin
          chk("result", m, out_data_a[m], exp_q[m].pop_front());
        end
      end
    end
  end

  task automatic chk_reset_vals(input int i);
    chk("rst_in_ready", i, 32'(in_ready_a[i]), 32'd1);
    chk("rst_out_valid", i, 32'(out_valid_a[i]), 32'd0);
    chk("rst_out_data", i, out_data_a[i], 32'd0);
    chk("rst_busy", i, 32'(busy_a[i]), 32'd0);
  endtask

  task automatic wait_accept(input int i, input string nm, output int acyc);
    bit hit;
    hit  = 1'b0;
    acyc = -1;
    for (int t = 0; t < 64 && !hit; t++) begin
      @(negedge clk);
      if (in_valid_a[i] && in_ready_a[i]) begin
        hit  = 1'b1;
        acyc = cyc;
      end
    end
    if (!hit) fail_timeout(nm, i);
  endtask

  task automatic send(input int i, input logic [47:0] w, input logic [31:0] e);
    int a;
    @(posedge clk); #1;
    in_valid_a[i] = 1'b1;
    in_data_a[i]  = w;
    wait_accept(i, "accept", a);
    if (a >= 0) exp_q[i].push_back(e);
    @(posedge clk); #1;
    in_valid_a[i] = 1'b0;
  endtask

  task automatic drain(input int i);
    for (int t = 0; t < 200 && exp_q[i].size() != 0; t++) @(negedge clk);
    if (exp_q[i].size() != 0) fail_timeout("drain", i);
  endtask

  task automatic lane_tests(input int i);
    int lat, bc, a1, a2, x0, k;
    bit seen;
    logic [47:0] w;
    logic [31:0] e;

    // latency and busy width on an all-ones word
    send(i, '1, R_ONES);
    lat = 0; bc = 0; seen = 1'b0;
    for (int t = 0; t < 32 && !seen; t++) begin
      @(negedge clk);
      if (out_valid_a[i]) seen = 1'b1;
      else begin
        lat++;
        if (busy_a[i]) bc++;
      end
    end
    if (!seen) fail_timeout("latency", i);
    else begin
      chk("latency", i, lat, beats_of(i));
      chk("busy_cycles", i, bc, beats_of(i));
      chk("busy_in_done", i, 32'(busy_a[i]), 32'd0);
    end
    drain(i);

    send(i, 48'h0, R_ZERO);
    drain(i);

    // back-to-back: second word accepted in the DONE cycle of the first
    @(posedge clk); #1;
    in_valid_a[i] = 1'b1;
    in_data_a[i]  = 48'h0;
    wait_accept(i, "b2b_first", a1);
    if (a1 >= 0) exp_q[i].push_back(R_ZERO);
    @(posedge clk); #1;
    in_data_a[i] = '1;
    wait_accept(i, "b2b_second", a2);
    if (a1 >= 0 && a2 >= 0) begin
      exp_q[i].push_back(R_ONES);
      chk("b2b_in_done", i, 32'(out_valid_a[i]), 32'd1);
      chk("b2b_period", i, a2 - a1, beats_of(i) + 1);
    end
    @(posedge clk); #1;
    in_valid_a[i] = 1'b0;
    drain(i);

    // backpressure for 10 cycles with in_data toggling
    @(posedge clk); #1;
    out_ready_a[i] = 1'b0;
    send(i, '1, R_ONES);
    seen = 1'b0;
    for (int t = 0; t < 32 && !seen; t++) begin
      @(negedge clk);
      seen = out_valid_a[i];
    end
    if (!seen) fail_timeout("bp_valid_wait", i);
    x0 = xfer_cnt[i];
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      in_valid_a[i] = 1'b1;
      in_data_a[i]  = n[0] ? 48'h5A5A_A5A5_0F0F : 48'h0;
      @(negedge clk);
      chk("bp_data", i, out_data_a[i], R_ONES);
      chk("bp_in_ready", i, 32'(in_ready_a[i]), 32'd0);
      chk("bp_valid", i, 32'(out_valid_a[i]), 32'd1);
      chk("bp_busy", i, 32'(busy_a[i]), 32'd0);
    end
    @(posedge clk); #1;
    in_valid_a[i]  = 1'b0;
    out_ready_a[i] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_one_xfer", i, xfer_cnt[i] - x0, 32'd1);
    chk("bp_idle", i, 32'(out_valid_a[i]), 32'd0);
    drain(i);

    // reset in the middle of RUN, then a clean word
    k = (beats_of(i) > 2) ? 2 : beats_of(i) - 1;
    @(posedge clk); #1;
    in_valid_a[i] = 1'b1;
    in_data_a[i]  = '1;
    wait_accept(i, "rst_accept", a1);
    @(posedge clk);
    repeat (k) @(posedge clk);
    #1;
    in_valid_a[i] = 1'b0;
    chk("rst_pre_busy", i, 32'(busy_a[i]), 32'd1);
    rst_n_a[i] = 1'b0;
    #1;
    chk_reset_vals(i);
    exp_q[i].delete();
    @(negedge clk);
    rst_n_a[i] = 1'b1;
    send(i, 48'h0, R_ZERO);
    drain(i);

    // per-box sweep with all other chunks zero
    for (int b = 0; b < 8; b++) begin
      for (int c = 0; c < 64; c++) begin
        w = '0;
        w[47 - 6 * b -: 6] = 6'(c);
        e = R_ZERO;
        e[31 - 4 * b -: 4] = ref_nib(b, 6'(c));
        send(i, w, e);
      end
    end
    drain(i);
  endtask

  initial begin
    rst_n_a     = '0;
    in_valid_a  = '0;
    out_ready_a = '1;
    for (int i = 0; i < NI; i++) in_data_a[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) chk_reset_vals(i);
    rst_n_a = '1;
    @(negedge clk);
    for (int i = 0; i < NI; i++) lane_tests(i);
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got no summary within time bound, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/des_sbox_seq.md
# des_sbox_seq

Parametrised, handshaked DES S-box substitution unit. It takes one 48-bit expanded-and-key-mixed word and returns the 32-bit S-box result (S1..S8 concatenated), ahead of the P-permutation. `LANES` sets how many S-box lookups run per cycle, which trades area against latency. It replaces the per-box combinational S-box modules inside the round function and sits between the key XOR and the P-permutation.

## Interface
Parameters:
- `LANES`, default 2: S-box lookups per cycle. Legal values are 1, 2, 4 and 8; any other value is an elaboration error.
- `BEATS`, derived as 8/`LANES`: cycles per word.

Ports:
- `clk`, in, 1: the single clock, rising-edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: `in_data` is valid.
- `in_ready`, out, 1: the unit can accept a word.
- `in_data`, in, 48: S1 chunk on [47:42], down to the S8 chunk on [5:0].
- `out_valid`, out, 1: `out_data` holds a completed result.
- `out_ready`, in, 1: the consumer accepts the result.
- `out_data`, out, 32: S1 result on [31:28], down to the S8 result on [3:0].
- `busy`, out, 1: high in RUN.

## Operation
- Chunk addressing is standard DES:
  - row = {c[5], c[0]}, column = c[4:1].
  - Row r, column k of box n returns the standard DES table entry.
  - Example: box S6, input 6'b000001 gives 10.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid` && `in_ready`, latch `in_data` into a 48-bit shift register, clear the beat counter, and go to RUN.
- RUN:
  - Each cycle, look up the `LANES` chunks at the top of the shift register. Lane j of beat b uses box index b*`LANES`+j.
  - Shift the shift register left by 6*`LANES`.
  - Shift the 4*`LANES` result bits into the 32-bit accumulator from the right.
  - Increment the counter. After the beat with counter == `BEATS`-1, go to DONE.
- DONE:
  - `out_valid` = 1. `out_data` = accumulator, held stable until `out_ready`.
  - On `out_ready` with `in_valid`, accept the new word in the same cycle and go to RUN (back-to-back).
  - On `out_ready` without `in_valid`, go to IDLE.
  - Otherwise stay in DONE.
- `in_ready` = (state == IDLE) || (state == DONE && `out_ready`). This is combinational from `out_ready`.
- `in_data` is sampled only on the accept edge. Later changes have no effect.
- `in_valid` during RUN is ignored. `in_ready` = 0 there, so no word is lost.
- Reset (async, any state): state → IDLE, counter → 0, shift register → 0, accumulator → 0. Any in-flight word is discarded.
- Output reset values: `in_ready` = 1, `out_valid` = 0, `out_data` = 0, `busy` = 0.
- After deassertion, the first acceptance can occur on the next rising edge.

## Timing
- Latency: `out_valid` rises `BEATS` clock edges after the accept edge (8, 4, 2 or 1 for `LANES` = 1, 2, 4, 8).
- Maximum throughput: one word per `BEATS`+1 cycles, using back-to-back acceptance in DONE.
- `out_valid` and `out_data` are registered outputs with no combinational path from inputs.
- The counter is ceil(log2(`BEATS`)) bits, minimum 1. It wraps only through the reset-to-0 on acceptance, never by overflow.
- Output backpressure (`out_ready` = 0) holds DONE indefinitely. Result bits and `busy` do not change while held.

## Structure
- Package `des_pkg`:
  - Constants: `DES_CHUNK_W` = 6, `DES_NIB_W` = 4, `DES_NBOX` = 8, `DES_EXP_W` = 48, `DES_HALF_W` = 32.
  - The 8×64 S-box constant table, indexed [box][row*16+col].
  - The state enum.
- Sub-module `des_sbox_lane`:
  - Combinational: box select [2:0] plus a 6-bit chunk in, 4-bit result out.
  - Instantiated `LANES` times with a generate loop.
  - Verified stand-alone against all 512 table entries.

## Test plan
- `LANES`=8: `in_data` = 48'h0, `out_ready` = 1 → `out_valid` one cycle after accept, `out_data` = 32'hEFA72C4D.
- `LANES`=1: `in_data` = 48'hFFFFFFFFFFFF → `out_valid` 8 cycles after accept, `out_data` = 32'hD9CE3DCB. `busy` is high for exactly 8 cycles.
- `LANES`=2, back-to-back:
  - Hold `in_valid` = 1 with words 0 and then all-ones, `out_ready` = 1.
  - Required: second word accepted in the DONE cycle of the first, results EFA72C4D then D9CE3DCB, period 5 cycles.
- Backpressure:
  - Hold `out_ready` = 0 for 10 cycles in DONE.
  - Required: `out_data` stable, `in_ready` = 0, `in_data` toggling ignored. After `out_ready`, exactly one result is transferred.
- Reset mid-RUN:
  - Assert `rst_n` = 0 at beat 2 with `LANES`=1.
  - Required: all outputs immediately at reset values. The next word is processed correctly with no residue.
- Exhaustive lane check for all four `LANES` values:
  - For each box, sweep that box's chunk over 0..63 with other chunks 0.
  - Required: only that nibble varies, matching the table. Example: S6 chunk 6'b000001 gives `out_data`[11:8] = 4'd10.
